pattern_shift_buffer: RTL
=========================

// Module: pattern_shift_buffer
// PURPOSE
//  Parametrised successor to the pattern update stage: captures a game/result value into a
//  DEPTH x WIDTH pattern array, one entry per rising edge of set. Two modes: shift (newest at [0])
//  and fill (write in order, stop when full). Adds saturation, a valid-entry count, full/done flags
//  and clear. Sits between the result generator and the pattern display/compare logic.
// PARAMETERS
//  WIDTH  5   bits per pattern entry
//  DEPTH  5   number of pattern entries
//  RES_W  12  width of incoming result
// PORTS
//  clk      in   1                    system clock, all state on rising edge
//  reset_n  in   1                    synchronous, active-low reset
//  set      in   1                    capture request; level, may be held many cycles
//  result   in   RES_W                value to capture (unsigned)
//  clear    in   1                    synchronous flush of array and count
//  mode     in   1                    0 = SHIFT, 1 = FILL
//  pattern  out  [DEPTH-1:0][WIDTH-1:0] stored entries, registered
//  count    out  $clog2(DEPTH+1)      number of valid entries, 0..DEPTH
//  full     out  1                    count == DEPTH
//  done     out  1                    one-cycle pulse on the cycle count becomes DEPTH
//  sat      out  1                    one-cycle pulse: captured result exceeded 2^WIDTH-1
//  drop     out  1                    one-cycle pulse: FILL-mode capture rejected (full)
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): pattern all 0, count 0, full/done/sat/drop 0, set_q 0.
//  Edge detect: set_q <= set every cycle; cap = set & ~set_q. Holding set high = one capture only.
//  Capture value: v = (result > 2^WIDTH-1) ? 2^WIDTH-1 : result[WIDTH-1:0]; sat pulses with the write.
//  Latency: cap sampled at edge N -> pattern/count/flags updated after edge N (visible cycle N+1).
//  SHIFT mode write: pattern[i] <= pattern[i-1] for i=DEPTH-1..1, pattern[0] <= v; oldest discarded;
//   count <= min(count+1, DEPTH). Never drops.
//  FILL mode write: if count < DEPTH: pattern[count] <= v, count++; else no write, drop pulses, sat 0.
//  done pulses only on the 0..DEPTH-1 -> DEPTH transition of count, either mode; not repeated while full.
//  full is combinational from registered count.
//  clear=1: pattern all 0, count 0, pulses 0; overrides a coincident cap (capture lost); set_q still updates.
//  reset_n=0 overrides clear and cap; mid-operation reset discards all entries.
//  mode change: effective on the next capture; existing entries and count unchanged.
//  Switching FILL->SHIFT when full: next capture shifts (oldest lost), no drop.
//  sat, drop, done are pulses, 0 on every cycle without the qualifying event.
// TESTING (WIDTH=5, DEPTH=5, RES_W=12)
//  SHIFT, captures 2,1,4,0,0 (set 1 cycle each, 2 idle) -> pattern[4:0]={2,1,4,0,0}, count 5, done once.
//  set held high 3 cycles with result=7 -> exactly one capture, count +1, pattern[0]=7.
//  result=40 captured -> pattern[0]=31, sat pulse 1 cycle; result=31 -> sat stays 0.
//  FILL, captures 3,5,7,9,11,13 -> pattern[0..4]={3,5,7,9,11}, full=1, drop pulses on 6th only.
//  SHIFT full, capture 6 -> pattern[0]=6, former pattern[4] lost, count stays 5, no done.
//  clear with coincident set edge -> all 0, count 0; reset_n=0 mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pattern_shift_buffer.sv
// pattern_shift_buffer: captures a saturated result value into a DEPTH x WIDTH
// pattern array on each rising edge of set. SHIFT mode pushes the newest value
// into entry 0, discarding the oldest; FILL mode writes entries in order and
// rejects captures once the array is full. Tracks a valid-entry count and
// raises one-cycle done/sat/drop pulses.
module pattern_shift_buffer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 5,
  parameter int RES_W = 12
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              set,
  input  logic [RES_W-1:0]                  result,
  input  logic                              clear,
  input  logic                              mode,
  output logic [DEPTH-1:0][WIDTH-1:0]       pattern,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              done,
  output logic                              sat,
  output logic                              drop
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [RES_W-1:0] MAX_RES = RES_W'((2**WIDTH) - 1);
  localparam logic             MODE_SHIFT = 1'b0;

  // Clamp an incoming result to the largest value an entry can hold.
  function automatic logic [WIDTH-1:0] clamp_value(input logic [RES_W-1:0] r);
    logic [WIDTH-1:0] v;
    if (r > MAX_RES) begin
      v = {WIDTH{1'b1}};
    end else begin
      v = r[WIDTH-1:0];
    end
    return v;
  endfunction

  logic                        set_q;
  logic [DEPTH-1:0][WIDTH-1:0] pattern_q, pattern_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        done_q, done_d;
  logic                        sat_q, sat_d;
  logic                        drop_q, drop_d;

  logic                        cap_s;
  logic                        over_s;
  logic [WIDTH-1:0]            cap_v_s;
  logic                        not_full_s;

  // Next-state computation: clear beats capture; capture behaviour depends on mode.
  always_comb begin
    cap_s      = set & ~set_q;
    over_s     = (result > MAX_RES);
    cap_v_s    = clamp_value(result);
    not_full_s = (count_q < DEPTH_C);
    pattern_d  = pattern_q;
    count_d    = count_q;
    done_d     = 1'b0;
    sat_d      = 1'b0;
    drop_d     = 1'b0;
    if (clear) begin
      pattern_d = '0;
      count_d   = '0;
    end else if (cap_s) begin
      if (mode == MODE_SHIFT) begin
        // Shift toward higher indices; the oldest entry falls off the end.
        for (int i = DEPTH - 1; i > 0; i--) begin
          pattern_d[i] = pattern_q[i-1];
        end
        pattern_d[0] = cap_v_s;
        sat_d        = over_s;
        if (not_full_s) begin
          count_d = count_q + CW'(1);
          done_d  = (count_q == (DEPTH_C - CW'(1)));
        end else begin
          count_d = count_q;
        end
      end else begin
        if (not_full_s) begin
          // Write at the first free slot, selected by the current count.
          for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == count_q) begin
              pattern_d[i] = cap_v_s;
            end else begin
              pattern_d[i] = pattern_q[i];
            end
          end
          count_d = count_q + CW'(1);
          sat_d   = over_s;
          done_d  = (count_q == (DEPTH_C - CW'(1)));
        end else begin
          drop_d = 1'b1;
        end
      end
    end else begin
      pattern_d = pattern_q;
      count_d   = count_q;
    end
  end

  // State registers with synchronous active-low reset; set_q tracks set every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      set_q     <= 1'b0;
      pattern_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      set_q     <= set;
      pattern_q <= pattern_d;
      count_q   <= count_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
    end
  end

  assign pattern = pattern_q;
  assign count   = count_q;
  assign full    = (count_q == DEPTH_C);
  assign done    = done_q;
  assign sat     = sat_q;
  assign drop    = drop_q;

endmodule
